// File: rtl/multdiv_sequencer.sv
// Sequences one multiply/divide through an external multdiv unit: latches the
// request, pulses the start strobe, waits for done or timeout, then holds the writeback.
module multdiv_sequencer #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        issue_valid,
  input  logic        issue_is_div,
  input  logic [31:0] issue_opA,
  input  logic [31:0] issue_opB,
  input  logic [4:0]  issue_rd,
  output logic        stall,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception,
  input  logic        wb_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [5:0] TIMEOUT_CNT = 6'(TIMEOUT);

  state_t      state, state_next;
  logic [5:0]  cycle_cnt;
  logic        is_div;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd;
  logic        done_seen, timed_out;

  // A done flag on the first RUN cycle may be left over from a previous op.
  assign done_seen = (cycle_cnt != '0) && md_resultRDY;
  assign timed_out = (cycle_cnt == TIMEOUT_CNT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    ctrl_MULT  = 1'b0;
    ctrl_DIV   = 1'b0;
    case (state)
      IDLE:  if (issue_valid) state_next = START;
      START: begin
        ctrl_DIV   = is_div;
        ctrl_MULT  = !is_div;
        state_next = RUN;
      end
      RUN:   if (done_seen || timed_out) state_next = DONE;
      DONE:  if (wb_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Gating with reset_n keeps stall low while reset is held, even if a request is present.
  assign stall    = (state != IDLE) || (issue_valid && reset_n);
  assign wb_valid = (state == DONE);
  assign wb_rd    = rd;
  assign md_opA   = op_a;
  assign md_opB   = op_b;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt    <= '0;
      is_div       <= 1'b0;
      op_a         <= '0;
      op_b         <= '0;
      rd           <= '0;
      wb_data      <= '0;
      wb_exception <= 1'b0;
    end else begin
      case (state)
        IDLE: if (issue_valid) begin
          op_a   <= issue_opA;
          op_b   <= issue_opB;
          rd     <= issue_rd;
          is_div <= issue_is_div;
        end
        START: cycle_cnt <= '0;
        RUN: begin
          if (done_seen) begin
            wb_data      <= (is_div && md_exception) ? '0 : md_result;
            wb_exception <= md_exception;
          end else if (timed_out) begin
            wb_data      <= '0;
            wb_exception <= 1'b1;
          end else begin
            cycle_cnt <= cycle_cnt + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench: the bench plays the multdiv unit and the writeback stage.
module tb_multdiv_sequencer;

  logic        clock;
  logic        reset_n;
  logic        issue_valid;
  logic        issue_is_div;
  logic [31:0] issue_opA;
  logic [31:0] issue_opB;
  logic [4:0]  issue_rd;
  logic        stall;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] md_opA;
  logic [31:0] md_opB;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exception;
  logic        wb_ready;

  int n_cmp;
  int n_bad;
  int n_mult_pulse;
  int n_div_pulse;
  int n_both_high;

  multdiv_sequencer #(.TIMEOUT(40)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .issue_valid  (issue_valid),
    .issue_is_div (issue_is_div),
    .issue_opA    (issue_opA),
    .issue_opB    (issue_opB),
    .issue_rd     (issue_rd),
    .stall        (stall),
    .ctrl_MULT    (ctrl_MULT),
    .ctrl_DIV     (ctrl_DIV),
    .md_opA       (md_opA),
    .md_opB       (md_opB),
    .md_result    (md_result),
    .md_exception (md_exception),
    .md_resultRDY (md_resultRDY),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_exception (wb_exception),
    .wb_ready     (wb_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    n_mult_pulse = 0;
    n_div_pulse  = 0;
    n_both_high  = 0;
  end

  always @(negedge clock) begin
    n_mult_pulse = n_mult_pulse + int'(ctrl_MULT);
    n_div_pulse  = n_div_pulse + int'(ctrl_DIV);
    if (ctrl_MULT && ctrl_DIV) n_both_high = n_both_high + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clock);
  endtask

  // Presents a request in IDLE and walks through START into the first RUN cycle.
  task automatic do_issue(input logic div, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rdv);
    issue_valid  = 1'b1;
    issue_is_div = div;
    issue_opA    = a;
    issue_opB    = b;
    issue_rd     = rdv;
    #1;
    check("stall_idle_req", 32'(stall), 32'd1);
    tick;
    issue_valid = 1'b0;
    issue_opA   = 32'h0BAD_0BAD;
    #1;
    check("start_ctrl_div", 32'(ctrl_DIV), 32'(div));
    check("start_ctrl_mult", 32'(ctrl_MULT), 32'(!div));
    check("start_opA", md_opA, a);
    check("start_opB", md_opB, b);
    tick;
    check("run_ctrl_off", {30'd0, ctrl_MULT, ctrl_DIV}, 32'd0);
    check("run_opA_stable", md_opA, a);
  endtask

  task automatic wait_wb;
    int n;
    n = 0;
    while (!wb_valid && n < 100) begin
      tick;
      n++;
    end
    if (!wb_valid) check("wb_valid_timeout", 32'(wb_valid), 32'd1);
  endtask

  task automatic respond(input int delay, input logic [31:0] res, input logic exc);
    repeat (delay) tick;
    md_result    = res;
    md_exception = exc;
    md_resultRDY = 1'b1;
    tick;
    md_resultRDY = 1'b0;
    md_exception = 1'b0;
    md_result    = 32'h5555_AAAA;
    wait_wb;
  endtask

  task automatic check_wb(input string tag, input logic [31:0] data, input logic exc,
                          input logic [4:0] rdv);
    check({tag, "_valid"}, 32'(wb_valid), 32'd1);
    check({tag, "_data"}, wb_data, data);
    check({tag, "_exc"}, 32'(wb_exception), 32'(exc));
    check({tag, "_rd"}, 32'(wb_rd), 32'(rdv));
    check({tag, "_stall"}, 32'(stall), 32'd1);
  endtask

  task automatic handshake(input string tag);
    wb_ready = 1'b1;
    tick;
    check({tag, "_hs_valid"}, 32'(wb_valid), 32'd0);
    check({tag, "_hs_stall"}, 32'(stall), 32'd0);
  endtask

  initial begin
    int m0, d0, n;
    n_cmp        = 0;
    n_bad        = 0;
    reset_n      = 1'b0;
    issue_valid  = 1'b0;
    issue_is_div = 1'b0;
    issue_opA    = '0;
    issue_opB    = '0;
    issue_rd     = '0;
    md_result    = '0;
    md_exception = 1'b0;
    md_resultRDY = 1'b0;
    wb_ready     = 1'b1;
    tick;
    tick;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_ctrl", {30'd0, ctrl_MULT, ctrl_DIV}, 32'd0);
    check("rst_wb", {wb_valid, wb_exception, wb_rd, 25'd0}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_opA", md_opA, 32'd0);
    reset_n = 1'b1;
    tick;

    // divide 100/7 with wb_ready held high
    m0 = n_mult_pulse; d0 = n_div_pulse;
    do_issue(1'b1, 32'd100, 32'd7, 5'd5);
    respond(2, 32'd14, 1'b0);
    check_wb("div100_7", 32'd14, 1'b0, 5'd5);
    handshake("div100_7");
    check("div100_7_divpulses", 32'(n_div_pulse - d0), 32'd1);
    check("div100_7_multpulses", 32'(n_mult_pulse - m0), 32'd0);

    // divide by zero: result from the unit is discarded
    do_issue(1'b1, 32'd5, 32'd0, 5'd12);
    respond(1, 32'hDEAD_BEEF, 1'b1);
    check_wb("div5_0", 32'd0, 1'b1, 5'd12);
    handshake("div5_0");

    // multiply -3*6
    m0 = n_mult_pulse; d0 = n_div_pulse;
    do_issue(1'b0, 32'hFFFF_FFFD, 32'd6, 5'd31);
    respond(3, 32'hFFFF_FFEE, 1'b0);
    check_wb("mul_m3_6", 32'hFFFF_FFEE, 1'b0, 5'd31);
    handshake("mul_m3_6");
    check("mul_m3_6_multpulses", 32'(n_mult_pulse - m0), 32'd1);
    check("mul_m3_6_divpulses", 32'(n_div_pulse - d0), 32'd0);

    // multiply exception keeps the unit's result; rd of 0 still writes back
    do_issue(1'b0, 32'd2, 32'd3, 5'd0);
    respond(1, 32'h1234_5678, 1'b1);
    check_wb("mul_exc_rd0", 32'h1234_5678, 1'b1, 5'd0);
    handshake("mul_exc_rd0");

    // timeout: done never arrives
    do_issue(1'b1, 32'd9, 32'd3, 5'd7);
    n = 0;
    while (!wb_valid && n < 100) begin
      tick;
      n++;
    end
    check("timeout_window", 32'((n >= 40) && (n <= 42)), 32'd1);
    check_wb("timeout", 32'd0, 1'b1, 5'd7);
    handshake("timeout");

    // writeback back-pressure with a competing issue
    wb_ready = 1'b0;
    m0 = n_mult_pulse; d0 = n_div_pulse;
    do_issue(1'b0, 32'd11, 32'd13, 5'd20);
    respond(2, 32'd143, 1'b0);
    for (int i = 0; i < 10; i++) begin
      issue_valid  = 1'b1;
      issue_is_div = 1'b1;
      issue_opA    = 32'd77;
      issue_opB    = 32'd1;
      issue_rd     = 5'd3;
      tick;
      check_wb("hold", 32'd143, 1'b0, 5'd20);
      check("hold_opA", md_opA, 32'd11);
    end
    check("hold_divpulses", 32'(n_div_pulse - d0), 32'd0);
    check("hold_multpulses", 32'(n_mult_pulse - m0), 32'd1);

    // wb_ready with a new request in the same DONE cycle: IDLE first
    wb_ready     = 1'b1;
    issue_is_div = 1'b0;
    issue_opA    = 32'd7;
    issue_opB    = 32'd8;
    issue_rd     = 5'd9;
    tick;
    check("ret_idle_valid", 32'(wb_valid), 32'd0);
    check("ret_idle_ctrl", {30'd0, ctrl_MULT, ctrl_DIV}, 32'd0);
    check("ret_idle_stall", 32'(stall), 32'd1);
    tick;
    issue_valid = 1'b0;
    check("ret_start_mult", 32'(ctrl_MULT), 32'd1);
    check("ret_start_opA", md_opA, 32'd7);
    tick;
    respond(2, 32'd56, 1'b0);
    check_wb("mul7_8", 32'd56, 1'b0, 5'd9);
    handshake("mul7_8");

    // reset mid-RUN aborts with no writeback
    do_issue(1'b1, 32'd50, 32'd5, 5'd17);
    tick;
    tick;
    reset_n = 1'b0;
    #1;
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_valid", 32'(wb_valid), 32'd0);
    check("mid_rst_data", wb_data, 32'd0);
    check("mid_rst_opA", md_opA, 32'd0);
    check("mid_rst_rd", 32'(wb_rd), 32'd0);
    tick;
    reset_n      = 1'b1;
    md_result    = 32'd10;
    md_resultRDY = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      n = n + int'(wb_valid);
    end
    md_resultRDY = 1'b0;
    check("post_rst_no_wb", 32'(n), 32'd0);

    // first request after reset release
    do_issue(1'b0, 32'd3, 32'd4, 5'd1);
    respond(1, 32'd12, 1'b0);
    check_wb("post_rst_mul", 32'd12, 1'b0, 5'd1);
    handshake("post_rst_mul");

    check("never_both_ctrl", 32'(n_both_high), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/multdiv_sequencer.md
MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 40: maximum RUN cycles allowed before the operation is aborted.
REQ-002 Port clock, input, 1: single rising-edge clock.
REQ-003 Port reset_n, input, 1: asynchronous active-low reset.
REQ-004 Port issue_valid, input, 1: the execute stage presents a mult/div request.
REQ-005 Port issue_is_div, input, 1: 1 = divide, 0 = multiply.
REQ-006 Port issue_opA and issue_opB, input, 32 each: operands.
REQ-007 Port issue_rd, input, 5: destination register.
REQ-008 Port stall, output, 1: holds the pipeline front end.
REQ-009 Port ctrl_MULT and ctrl_DIV, output, 1 each: start pulses to the multdiv unit.
REQ-010 Port md_opA and md_opB, output, 32 each: latched operands driven to the multdiv unit.
REQ-011 Port md_result, input, 32: result from the multdiv unit.
REQ-012 Port md_exception and md_resultRDY, input, 1 each: exception and done flags from the multdiv unit.
REQ-013 Port wb_valid, output, 1: a writeback is pending.
REQ-014 Port wb_rd, output, 5: writeback destination register.
REQ-015 Port wb_data, output, 32: writeback data.
REQ-016 Port wb_exception, output, 1: divide-by-zero or timeout occurred.
REQ-017 Port wb_ready, input, 1: the writeback stage accepts the pending result.

Function
REQ-018 States SHALL be IDLE, START, RUN, DONE, encoded in 2 bits.
REQ-019 IDLE with issue_valid=1 SHALL latch opA, opB, rd and is_div, then go to START on the next edge.
REQ-020 START SHALL assert exactly one of ctrl_DIV or ctrl_MULT for exactly one cycle, chosen by latched is_div, then go to RUN.
REQ-021 md_opA and md_opB SHALL come from the latched registers and SHALL stay stable from START until the exit from RUN.
REQ-022 RUN SHALL increment a 6-bit cycle counter that starts at 0 on entry to RUN.
REQ-023 md_resultRDY SHALL be ignored in START and on the first RUN cycle, so that a stale done flag is not taken.
REQ-024 RUN with md_resultRDY=1 (counter>=1) SHALL capture md_result into wb_data and md_exception into wb_exception, then go to DONE.
REQ-025 A divide with md_exception=1 SHALL force wb_data to 32'd0.
REQ-026 RUN reaching counter==TIMEOUT without done SHALL go to DONE with wb_data=0 and wb_exception=1.
REQ-027 DONE SHALL hold wb_valid=1 with stable wb_rd, wb_data and wb_exception until wb_ready=1, then go to IDLE.
REQ-028 stall SHALL be 1 in START, RUN and DONE, and also combinationally in IDLE while issue_valid=1; it SHALL be 0 otherwise.
REQ-029 issue_valid in any state other than IDLE SHALL be ignored; the upstream holds its request while stall=1.
REQ-030 wb_ready=1 and issue_valid=1 in the same DONE cycle SHALL return to IDLE only; the new request is taken from IDLE on the following cycle.
REQ-031 A wb_rd value of 0 SHALL still complete the handshake, and wb_valid SHALL assert normally.
REQ-032 ctrl_MULT and ctrl_DIV SHALL never be high simultaneously and SHALL be 0 outside START.

Reset
REQ-033 reset_n=0 SHALL asynchronously force IDLE, counter=0, and all latched registers and outputs to 0 (stall, ctrl_*, wb_*).
REQ-034 Reset asserted mid-RUN or mid-DONE SHALL abort the operation with no writeback.
REQ-035 After reset release, the first edge with issue_valid=1 SHALL behave per REQ-019.

Verification
REQ-036 Divide 100/7, wb_ready held at 1 -> one ctrl_DIV pulse, then wb_valid with wb_data=14, wb_exception=0, correct wb_rd.
REQ-037 Divide 5/0 -> wb_data=0, wb_exception=1, stall deasserts after the handshake.
REQ-038 Multiply -3*6 -> one ctrl_MULT pulse, wb_data=32'hFFFFFFEE, no ctrl_DIV seen at any point.
REQ-039 md_resultRDY held at 0 -> wb_exception=1 and wb_data=0 after TIMEOUT RUN cycles (40).
REQ-040 wb_ready held at 0 for 10 cycles in DONE -> wb_* outputs stable, stall=1, and a second issue is ignored.
REQ-041 reset_n pulsed low mid-RUN -> all outputs are 0 immediately, with no wb_valid afterwards.
